bytes_to_block: RTL and testbench

Parametrised byte-to-block deserializer for the CubeHash input path. It collects `NBYTES` words of `DATA_W` bits, strobed in from the Raspberry Pi Zero GPIO interface, into one `DATA_W*NBYTES`-bit message block. It generalises the fixed 32×8 collector with four additions: configurable width and depth, selectable byte order, a ready/valid output handshake with one pending-block buffer, and an overflow flag plus a resynchronisation input. It sits between the GPIO pins and the hash core's block input.

---
 rtl/bytes_to_block.sv | 152 +++++++++++++++
 tb/tb_bytes_to_block.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytes_to_block.sv
// Collects NBYTES strobed words from the GPIO pins into one message block,
// with a strobe synchroniser, one pending-block buffer and a ready/valid output.
module bytes_to_block #(
  parameter int DATA_W      = 8,
  parameter int NBYTES      = 32,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  localparam int BLK_W      = DATA_W * NBYTES,
  localparam int CW         = $clog2(NBYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              in_en,
  input  logic [DATA_W-1:0] part_msg1,
  input  logic              load1,
  input  logic              sync_clr,
  input  logic              msg_ready,
  output logic [BLK_W-1:0]  msg,
  output logic              msg_valid,
  output logic              done,
  output logic              overflow,
  output logic [CW-1:0]     byte_cnt
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [BLK_W-1:0]       tmp_blk_q, tmp_blk_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BLK_W-1:0]       msg_q, msg_d;
  logic                   msg_valid_q, msg_valid_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;

  logic                   strobe;
  logic                   xfer;
  logic                   accept;
  logic [CW-1:0]          slot;

  // Next-state logic: synchroniser, word capture/write, block transfer, handshake.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], load1};
    hist_d      = sync_q[SYNC_STAGES-1];
    strobe      = sync_q[SYNC_STAGES-1] & ~hist_q & in_en;
    xfer        = (state_q == FULL) && (!msg_valid_q || msg_ready);
    accept      = msg_valid_q & msg_ready;
    slot        = (MSB_FIRST != 0) ? (CW'(NBYTES - 1) - cnt_q) : cnt_q;

    state_d     = state_q;
    word_d      = word_q;
    wr_pend_d   = wr_pend_q;
    tmp_blk_d   = tmp_blk_q;
    cnt_d       = cnt_q;
    msg_d       = msg_q;
    msg_valid_d = msg_valid_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;

    if (accept) begin
      msg_valid_d = 1'b0;
    end else begin
      msg_valid_d = msg_valid_q;
    end

    if (sync_clr) begin
      // Resync drops the partial/pending block; the output side is left alone.
      cnt_d      = '0;
      tmp_blk_d  = '0;
      wr_pend_d  = 1'b0;
      overflow_d = 1'b0;
      state_d    = COLLECT;
    end else begin
      case (state_q)
        COLLECT: begin
          if (wr_pend_q) begin
            tmp_blk_d[slot * DATA_W +: DATA_W] = word_q;
            cnt_d     = cnt_q + CW'(1);
            wr_pend_d = 1'b0;
            state_d   = (cnt_q == CW'(NBYTES - 1)) ? FULL : COLLECT;
          end else begin
            state_d = COLLECT;
          end
        end
        FULL: begin
          if (xfer) begin
            msg_d       = tmp_blk_q;
            msg_valid_d = 1'b1;
            done_d      = 1'b1;
            cnt_d       = '0;
            tmp_blk_d   = '0;
            state_d     = COLLECT;
          end else begin
            state_d = FULL;
          end
        end
        default: state_d = COLLECT;
      endcase

      // A strobe in the transfer cycle is kept and lands in slot 0 next.
      if (strobe) begin
        if ((state_q == FULL) && !xfer) begin
          overflow_d = 1'b1;
        end else begin
          word_d    = part_msg1;
          wr_pend_d = 1'b1;
        end
      end else begin
        overflow_d = overflow_d;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q     <= COLLECT;
      sync_q      <= '0;
      hist_q      <= 1'b0;
      word_q      <= '0;
      wr_pend_q   <= 1'b0;
      tmp_blk_q   <= '0;
      cnt_q       <= '0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      hist_q      <= hist_d;
      word_q      <= word_d;
      wr_pend_q   <= wr_pend_d;
      tmp_blk_q   <= tmp_blk_d;
      cnt_q       <= cnt_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign msg       = msg_q;
  assign msg_valid = msg_valid_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_bytes_to_block.sv
// Self-checking bench for bytes_to_block: default 32x8 MSB-first instance plus
// a 4x16 LSB-first instance, checked against a word-list reference model.
module tb_bytes_to_block;

  typedef logic [7:0] byte_q_t[$];

  logic         clk = 1'b0;
  logic         rst_p = 1'b1;
  logic         in_en = 1'b1;
  logic [7:0]   part_msg1 = 8'h00;
  logic         load1 = 1'b0;
  logic         sync_clr = 1'b0;
  logic         msg_ready = 1'b1;
  logic [255:0] msg;
  logic         msg_valid;
  logic         done;
  logic         overflow;
  logic [5:0]   byte_cnt;

  logic [15:0]  part2 = 16'h0000;
  logic         load2 = 1'b0;
  logic [63:0]  msg2;
  logic         valid2;
  logic         done2;
  logic         ovf2;
  logic [2:0]   cnt2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] got_q[$];
  logic         vld_q[$];
  logic         after_q[$];
  logic         prev_done = 1'b0;
  logic [63:0]  got2_q[$];
  logic [255:0] last_msg;

  always #5 clk = ~clk;

  bytes_to_block dut (
    .clk(clk), .rst_p(rst_p), .in_en(in_en), .part_msg1(part_msg1), .load1(load1),
    .sync_clr(sync_clr), .msg_ready(msg_ready), .msg(msg), .msg_valid(msg_valid),
    .done(done), .overflow(overflow), .byte_cnt(byte_cnt)
  );

  bytes_to_block #(.DATA_W(16), .NBYTES(4), .MSB_FIRST(0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_p(rst_p), .in_en(1'b1), .part_msg1(part2), .load1(load2),
    .sync_clr(1'b0), .msg_ready(1'b1), .msg(msg2), .msg_valid(valid2),
    .done(done2), .overflow(ovf2), .byte_cnt(cnt2)
  );

  // Record every delivered block, msg_valid at delivery and one cycle later.
  always @(posedge clk) begin
    #1;
    if (prev_done) after_q.push_back(msg_valid);
    prev_done = done;
    if (done) begin
      got_q.push_back(msg);
      vld_q.push_back(msg_valid);
    end
    if (done2) got2_q.push_back(msg2);
  end

  // Word 0 ends up most significant: shift-and-append.
  function automatic logic [255:0] model_msb(input byte_q_t w);
    logic [255:0] b = '0;
    foreach (w[i]) b = (b << 8) | 256'(w[i]);
    return b;
  endfunction

  function automatic logic [63:0] model_lsb16(input logic [15:0] w0, input logic [15:0] w1,
                                              input logic [15:0] w2, input logic [15:0] w3);
    return 64'(w0) + (64'(w1) << 16) + (64'(w2) << 32) + (64'(w3) << 48);
  endfunction

  function automatic byte_q_t rand_words(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send_word(input logic [7:0] d, input int hi);
    @(negedge clk);
    part_msg1 = d;
    load1 = 1'b1;
    repeat (hi) @(negedge clk);
    load1 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_block(input byte_q_t w);
    foreach (w[i]) send_word(w[i], int'($urandom_range(1, 3)));
  endtask

  task automatic send_word2(input logic [15:0] d);
    @(negedge clk);
    part2 = d;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_blocks(input int n);
    int b = 0;
    while (got_q.size() < n && b < 200) begin
      @(negedge clk);
      b++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_q();
    got_q.delete();
    vld_q.delete();
    after_q.delete();
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    repeat (4) @(negedge clk);
    rst_p = 1'b0;
    tests_run++; if (msg !== 256'd0) begin tests_failed++; $display("FAIL reset_msg: got %h want 0", msg); end
    tests_run++; if (msg_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", msg_valid); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
  endtask

  task automatic test_basic();
    byte_q_t w;
    logic [255:0] exp;
    for (int i = 0; i < 32; i++) w.push_back(8'(i));
    exp = model_msb(w);
    clear_q();
    msg_ready = 1'b1;
    for (int i = 0; i < 32; i++) send_word(w[i], 1);
    wait_blocks(1);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL basic_done_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++; if (got_q[0] !== exp) begin tests_failed++; $display("FAIL basic_msg: got %h want %h", got_q[0], exp); end
      tests_run++; if (vld_q[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_valid_rise: got %b want 1", vld_q[0]); end
    end
    if (after_q.size() > 0) begin
      tests_run++; if (after_q[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop: got %b want 0", after_q[0]); end
    end
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL basic_cnt: got %0d want 0", byte_cnt); end
    last_msg = exp;
  endtask

  task automatic test_random_blocks();
    byte_q_t blks[3];
    clear_q();
    msg_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      blks[b] = rand_words(32);
      send_block(blks[b]);
    end
    wait_blocks(3);
    tests_run++; if (got_q.size() !== 3) begin tests_failed++; $display("FAIL rand_count: got %0d want 3", got_q.size()); end
    for (int b = 0; b < 3; b++) begin
      if (got_q.size() > b) begin
        tests_run++;
        if (got_q[b] !== model_msb(blks[b])) begin
          tests_failed++; $display("FAIL rand_msg%0d: got %h want %h", b, got_q[b], model_msb(blks[b]));
        end
      end
    end
    last_msg = model_msb(blks[2]);
  endtask

  task automatic test_variant();
    logic [15:0] r[4];
    int b;
    got2_q.delete();
    send_word2(16'hAAAA); send_word2(16'hBBBB); send_word2(16'hCCCC); send_word2(16'hDDDD);
    for (int i = 0; i < 4; i++) begin
      r[i] = 16'($urandom);
      send_word2(r[i]);
    end
    b = 0;
    while (got2_q.size() < 2 && b < 100) begin @(negedge clk); b++; end
    tests_run++; if (got2_q.size() !== 2) begin tests_failed++; $display("FAIL var_count: got %0d want 2", got2_q.size()); end
    if (got2_q.size() > 0) begin
      tests_run++; if (got2_q[0] !== 64'hDDDDCCCCBBBBAAAA) begin tests_failed++; $display("FAIL var_fixed: got %h want DDDDCCCCBBBBAAAA", got2_q[0]); end
    end
    if (got2_q.size() > 1) begin
      tests_run++;
      if (got2_q[1] !== model_lsb16(r[0], r[1], r[2], r[3])) begin
        tests_failed++; $display("FAIL var_rand: got %h want %h", got2_q[1], model_lsb16(r[0], r[1], r[2], r[3]));
      end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t a, bb;
    a = rand_words(32);
    bb = rand_words(32);
    clear_q();
    msg_ready = 1'b0;
    send_block(a);
    send_block(bb);
    send_word(8'h77, 1);
    repeat (4) @(negedge clk);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL bp_count1: got %0d want 1", got_q.size()); end
    tests_run++; if (msg !== model_msb(a)) begin tests_failed++; $display("FAIL bp_first: got %h want %h", msg, model_msb(a)); end
    tests_run++; if (msg_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: got %b want 1", msg_valid); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    tests_run++; if (byte_cnt !== 6'd32) begin tests_failed++; $display("FAIL bp_cnt_full: got %0d want 32", byte_cnt); end
    @(negedge clk); msg_ready = 1'b1;
    @(negedge clk); msg_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (got_q.size() !== 2) begin tests_failed++; $display("FAIL bp_count2: got %0d want 2", got_q.size()); end
    if (got_q.size() > 1) begin
      tests_run++; if (got_q[1] !== model_msb(bb)) begin tests_failed++; $display("FAIL bp_second: got %h want %h", got_q[1], model_msb(bb)); end
    end
    if (after_q.size() > 1) begin
      tests_run++; if (after_q[1] !== 1'b1) begin tests_failed++; $display("FAIL bp_valid_stays: got %b want 1", after_q[1]); end
    end
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL bp_cnt_after: got %0d want 0", byte_cnt); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    last_msg = model_msb(bb);
  endtask

  task automatic test_resync();
    byte_q_t part, c;
    part = rand_words(17);
    c = rand_words(32);
    clear_q();
    send_block(part);
    repeat (2) @(negedge clk);
    tests_run++; if (byte_cnt !== 6'd17) begin tests_failed++; $display("FAIL rs_cnt17: got %0d want 17", byte_cnt); end
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL rs_cnt: got %0d want 0", byte_cnt); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rs_overflow: got %b want 0", overflow); end
    tests_run++; if (msg !== last_msg) begin tests_failed++; $display("FAIL rs_msg_kept: got %h want %h", msg, last_msg); end
    tests_run++; if (msg_valid !== 1'b1) begin tests_failed++; $display("FAIL rs_valid_kept: got %b want 1", msg_valid); end
    tests_run++; if (got_q.size() !== 0) begin tests_failed++; $display("FAIL rs_no_done: got %0d want 0", got_q.size()); end
    msg_ready = 1'b1;
    send_block(c);
    wait_blocks(1);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL rs_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++; if (got_q[0] !== model_msb(c)) begin tests_failed++; $display("FAIL rs_clean: got %h want %h", got_q[0], model_msb(c)); end
    end
    last_msg = model_msb(c);
  endtask

  task automatic test_strobe_shape();
    @(negedge clk);
    part_msg1 = 8'h5A;
    load1 = 1'b1;
    repeat (50) @(negedge clk);
    load1 = 1'b0;
    repeat (3) @(negedge clk);
    send_word(8'hA5, 1);
    tests_run++; if (byte_cnt !== 6'd2) begin tests_failed++; $display("FAIL shape_two: got %0d want 2", byte_cnt); end
    in_en = 1'b0;
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 1);
    tests_run++; if (byte_cnt !== 6'd2) begin tests_failed++; $display("FAIL shape_disabled: got %0d want 2", byte_cnt); end
    @(negedge clk); load1 = 1'b1;
    repeat (5) @(negedge clk);
    in_en = 1'b1;
    repeat (5) @(negedge clk);
    load1 = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (byte_cnt !== 6'd2) begin tests_failed++; $display("FAIL shape_reenable: got %0d want 2", byte_cnt); end
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL shape_clr: got %0d want 0", byte_cnt); end
  endtask

  task automatic test_reset_mid();
    byte_q_t a, bb, d;
    a = rand_words(32);
    bb = rand_words(32);
    d = rand_words(32);
    clear_q();
    for (int i = 0; i < 9; i++) send_word(8'($urandom), 1);
    @(negedge clk); part_msg1 = 8'hC3; load1 = 1'b1;
    @(negedge clk); load1 = 1'b0; rst_p = 1'b1;
    @(negedge clk); rst_p = 1'b0;
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL rm_cnt: got %0d want 0", byte_cnt); end
    tests_run++; if (msg !== 256'd0) begin tests_failed++; $display("FAIL rm_msg: got %h want 0", msg); end
    tests_run++; if (msg_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_valid: got %b want 0", msg_valid); end
    repeat (4) @(negedge clk);
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL rm_no_strobe: got %0d want 0", byte_cnt); end
    msg_ready = 1'b0;
    send_block(a);
    send_block(bb);
    repeat (2) @(negedge clk);
    tests_run++; if (byte_cnt !== 6'd32) begin tests_failed++; $display("FAIL rm_full: got %0d want 32", byte_cnt); end
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    tests_run++; if (msg !== 256'd0) begin tests_failed++; $display("FAIL rm2_msg: got %h want 0", msg); end
    tests_run++; if (msg_valid !== 1'b0) begin tests_failed++; $display("FAIL rm2_valid: got %b want 0", msg_valid); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL rm2_done: got %b want 0", done); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL rm2_overflow: got %b want 0", overflow); end
    tests_run++; if (byte_cnt !== 6'd0) begin tests_failed++; $display("FAIL rm2_cnt: got %0d want 0", byte_cnt); end
    clear_q();
    msg_ready = 1'b1;
    send_block(d);
    wait_blocks(1);
    tests_run++; if (got_q.size() !== 1) begin tests_failed++; $display("FAIL rm_count: got %0d want 1", got_q.size()); end
    if (got_q.size() > 0) begin
      tests_run++; if (got_q[0] !== model_msb(d)) begin tests_failed++; $display("FAIL rm_block: got %h want %h", got_q[0], model_msb(d)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random_blocks();
    test_variant();
    test_backpressure();
    test_resync();
    test_strobe_shape();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
